uart_param_core: RTL and testbench
==================================

# uart_param_core

Parametrised full-duplex UART transceiver: the next generation of the team's fixed 8N1 UART top. Configurable character width, parity and stop bits, plus RX error detection and an internal loopback mode. One transmitter and one receiver share a single clock domain. A system bench or CPU-side wrapper drives the byte-level handshake; `tx_serial`/`rx_serial` go to pads or to a peer UART.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be even and ≥ 4.
- `DATA_BITS`, 8: character width, legal 5–9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: legal 1 or 2.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `tx_start` in 1: request to send `tx_data`; sampled only while `tx_busy`=0.
- `tx_data` in DATA_BITS: character to send; captured on the accepting edge.
- `tx_busy` out 1: transmitter owns a frame.
- `tx_done` out 1: one-cycle pulse at frame end.
- `tx_serial` out 1: serial output; idle high.
- `rx_serial` in 1: asynchronous serial input.
- `loopback` in 1: 1 routes the internal TX line to the RX input.
- `rx_done` out 1: one-cycle pulse; character available.
- `rx_data` out DATA_BITS: last received character; held until the next `rx_done`.
- `rx_parity_err` out 1: parity mismatch on the last character; updated with `rx_done`.
- `rx_frame_err` out 1: a stop-bit sample was 0 on the last character; updated with `rx_done`.

## Operation
- Frame length F = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS bits. Order: start (0), data LSB first, parity, stop (1).
- Parity bit: XOR of the data bits for even parity; inverted XOR for odd parity.
- TX FSM, states IDLE → START → DATA → PARITY (skipped if PARITY=0) → STOP → IDLE.
  - A bit counter and a baud counter (width clog2(CLKS_PER_BIT)) pace each bit.
  - `tx_data` is latched into a shift register on acceptance.
  - `tx_start` while busy is ignored; there is no queueing.
- RX input path:
  - Mux selects `rx_serial` or the internal TX line according to `loopback`.
  - The selected line passes through a 2-flop synchroniser, which resets to 1.
- RX FSM, states IDLE → START → DATA → PARITY → STOP → (BREAK) → IDLE.
  - IDLE: a synchronised 1→0 transition starts a half-bit count (CLKS_PER_BIT/2).
  - START: the line is re-sampled at mid-bit. If it is 1, the event is a glitch: return to IDLE with no pulse.
  - Data, parity and every stop bit are sampled at mid-bit, i.e. every CLKS_PER_BIT cycles thereafter.
  - After the last stop sample: update `rx_data` and both error flags, then pulse `rx_done`. The data is delivered even on error.
  - If the final stop sample was 0, enter BREAK and wait for the synchronised line to be 1 before IDLE. No spurious start is taken from a held-low line.
- Loopback:
  - With `loopback`=1, `tx_serial` is forced to 1 and the external `rx_serial` is ignored.
  - `loopback` is changed only while both FSMs are idle. A mid-frame change must not hang either FSM; a garbage character or a frame error is acceptable.
- Full duplex: TX and RX run independently; simultaneous `tx_start` and an RX frame are legal.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - `tx_serial`=1.
  - `tx_busy`, `tx_done`, `rx_done`, `rx_parity_err`, `rx_frame_err` = 0.
  - `rx_data`=0.
  - Both FSMs in IDLE; all counters 0.
- Reset mid-frame aborts immediately. After release, the first frame is clean, with no stale pulses.
- TX, with `tx_start` accepted at edge k:
  - `tx_busy`=1 and `tx_serial`=0 from k+1.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - At edge k+1+F·CLKS_PER_BIT, `tx_busy` falls and `tx_done` is 1 for that one cycle.
  - `tx_start` at that same edge is accepted; back-to-back frames have zero idle gap.
- RX, measured from the start-bit falling edge on the RX input line:
  - `rx_done` rises (F−0.5)·CLKS_PER_BIT + 3 cycles later (±1).
  - `rx_done` is never high for two consecutive cycles.
- The error flags and `rx_data` change only on the `rx_done` cycle.

## Test plan
- **Reset and 8N1 loopback.**
  - Stimulus: `loopback`=1, defaults; send "s" (0x73), then "craft" back-to-back on `tx_done`.
  - Required: each `rx_data` matches in order, with flags 0. Each `tx_busy` high window is exactly 160 cycles.
- **9-bit even parity, 2 stop bits.**
  - Stimulus: DATA_BITS=9, PARITY=2, STOP_BITS=2, loopback; send 0x1FF and 0x001.
  - Required: frame length 13·CLKS_PER_BIT. Parity bit 1 for 0x1FF and 1 for 0x001; `rx_parity_err`=0.
- **Parity error.**
  - Stimulus: PARITY=1; bench drives `rx_serial` with 0x41 and a wrong parity bit.
  - Required: `rx_done` pulse, `rx_data`=0x41, `rx_parity_err`=1, `rx_frame_err`=0.
  - The next good frame clears the flag.
- **Framing error and break.**
  - Stimulus: stop bit driven 0, then the line held low for 3 bit times before a valid 0x55 frame.
  - Required: one `rx_done` with `rx_frame_err`=1, no extra pulses during the low period, then 0x55 with flags 0.
- **Glitch rejection.**
  - Stimulus: a 0-pulse of CLKS_PER_BIT/4 cycles on `rx_serial`.
  - Required: no `rx_done`, and RX is back in IDLE.
- **Reset mid-frame.**
  - Stimulus: assert `rst_n`=0 halfway through the DATA bits of a TX/loopback frame.
  - Required: all outputs go to reset values immediately. After release, a clean transfer of 0xA5 completes.
- **`tx_start` while busy.**
  - Stimulus: pulse `tx_start` with 0x00 mid-frame.
  - Required: it is ignored; only the original character is received.

Source files
------------

// File: rtl/uart_param_core_if.sv
// Byte-level and serial-line signals of one uart_param_core instance.
// Handshake: tx_start is the valid, ~tx_busy the ready; a character moves on any rising
// edge where both are high, and tx_start is ignored while tx_busy is high.
interface uart_param_core_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_busy;
  logic                 tx_done;
  logic                 tx_serial;
  logic                 rx_serial;
  logic                 loopback;
  logic                 rx_done;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_parity_err;
  logic                 rx_frame_err;

  modport master (
    output tx_start, tx_data, rx_serial, loopback,
    input  tx_busy, tx_done, tx_serial, rx_done, rx_data, rx_parity_err, rx_frame_err
  );

  modport slave (
    input  tx_start, tx_data, rx_serial, loopback,
    output tx_busy, tx_done, tx_serial, rx_done, rx_data, rx_parity_err, rx_frame_err
  );
endinterface

// File: rtl/uart_param_core.sv
// Full-duplex UART with configurable width, parity and stop bits, RX error flags and
// internal loopback. TX and RX are independent FSMs sharing one clock.
module uart_param_core #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_param_core_if.slave   bus,
  output logic [2:0]         tx_state_o,
  output logic [2:0]         rx_state_o
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = 4;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam bit HAS_PAR = (PARITY != 0);
  localparam bit ODD_PAR = (PARITY == 1);

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_e;

  // ---------------------------------------------------------------- transmitter
  tx_state_e            tx_state_q;
  logic [BAUD_W-1:0]    tx_baud_q;
  logic [BIT_W-1:0]     tx_bit_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 tx_par_q;
  logic                 tx_line_q;
  logic                 tx_busy_q;
  logic                 tx_done_q;
  logic                 tx_bit_end;

  assign tx_bit_end = (tx_baud_q == BAUD_LAST);

  // tx_line_q changes on the same edge the FSM advances, so each bit is exactly one
  // baud period on the line and the start bit appears the cycle after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_line_q  <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      if (tx_state_q != TX_IDLE) begin
        tx_baud_q <= tx_bit_end ? '0 : tx_baud_q + 1'b1;
      end
      case (tx_state_q)
        TX_IDLE: begin
          if (bus.tx_start) begin
            tx_state_q <= TX_START;
            tx_shift_q <= bus.tx_data;
            tx_par_q   <= (^bus.tx_data) ^ ODD_PAR;
            tx_line_q  <= 1'b0;
            tx_busy_q  <= 1'b1;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_state_q <= TX_DATA;
            tx_line_q  <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            if (tx_bit_q == DATA_LAST) begin
              tx_bit_q <= '0;
              if (HAS_PAR) begin
                tx_state_q <= TX_PARITY;
                tx_line_q  <= tx_par_q;
              end else begin
                tx_state_q <= TX_STOP;
                tx_line_q  <= 1'b1;
              end
            end else begin
              tx_bit_q   <= tx_bit_q + 1'b1;
              tx_line_q  <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
            end
          end
        end
        TX_PARITY: begin
          if (tx_bit_end) begin
            tx_state_q <= TX_STOP;
            tx_line_q  <= 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_bit_end) begin
            if (tx_bit_q == STOP_LAST) begin
              tx_state_q <= TX_IDLE;
              tx_busy_q  <= 1'b0;
              tx_done_q  <= 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q + 1'b1;
            end
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- receive input path
  logic rx_sel;
  logic rx_meta_q;
  logic rx_sync_q;
  logic rx_prev_q;

  assign rx_sel = bus.loopback ? tx_line_q : bus.rx_serial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_sel;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // ---------------------------------------------------------------- receiver
  rx_state_e            rx_state_q;
  logic [BAUD_W-1:0]    rx_baud_q;
  logic [BIT_W-1:0]     rx_bit_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic                 rx_par_bit_q;
  logic                 rx_ferr_acc_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_perr_q;
  logic                 rx_ferr_q;
  logic                 rx_done_q;
  logic                 rx_sample;

  // The start bit is checked half a bit after the edge; every later sample is a full
  // bit apart, which places all of them at mid-bit.
  assign rx_sample = (rx_state_q == RX_START) ? (rx_baud_q == BAUD_HALF)
                                              : (rx_baud_q == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q    <= RX_IDLE;
      rx_baud_q     <= '0;
      rx_bit_q      <= '0;
      rx_shift_q    <= '0;
      rx_par_bit_q  <= 1'b0;
      rx_ferr_acc_q <= 1'b0;
      rx_data_q     <= '0;
      rx_perr_q     <= 1'b0;
      rx_ferr_q     <= 1'b0;
      rx_done_q     <= 1'b0;
    end else begin
      rx_done_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_state_q <= RX_START;
            rx_baud_q  <= '0;
          end
        end
        RX_START: begin
          if (rx_sample) begin
            rx_baud_q <= '0;
            rx_bit_q  <= '0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_baud_q <= rx_baud_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_sample) begin
            rx_baud_q  <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
            if (rx_bit_q == DATA_LAST) begin
              rx_bit_q      <= '0;
              rx_ferr_acc_q <= 1'b0;
              rx_state_q    <= HAS_PAR ? RX_PARITY : RX_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + 1'b1;
            end
          end else begin
            rx_baud_q <= rx_baud_q + 1'b1;
          end
        end
        RX_PARITY: begin
          if (rx_sample) begin
            rx_baud_q    <= '0;
            rx_par_bit_q <= rx_sync_q;
            rx_state_q   <= RX_STOP;
          end else begin
            rx_baud_q <= rx_baud_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_sample) begin
            rx_baud_q <= '0;
            if (rx_bit_q == STOP_LAST) begin
              // Deliver even on error; a low final stop means the line may be in break.
              rx_bit_q   <= '0;
              rx_data_q  <= rx_shift_q;
              rx_perr_q  <= HAS_PAR & ((^rx_shift_q) ^ rx_par_bit_q ^ ODD_PAR);
              rx_ferr_q  <= rx_ferr_acc_q | ~rx_sync_q;
              rx_done_q  <= 1'b1;
              rx_state_q <= rx_sync_q ? RX_IDLE : RX_BREAK;
            end else begin
              rx_bit_q      <= rx_bit_q + 1'b1;
              rx_ferr_acc_q <= rx_ferr_acc_q | ~rx_sync_q;
            end
          end else begin
            rx_baud_q <= rx_baud_q + 1'b1;
          end
        end
        RX_BREAK: begin
          if (rx_sync_q) begin
            rx_state_q <= RX_IDLE;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- outputs
  assign bus.tx_busy       = tx_busy_q;
  assign bus.tx_done       = tx_done_q;
  assign bus.tx_serial     = bus.loopback ? 1'b1 : tx_line_q;
  assign bus.rx_done       = rx_done_q;
  assign bus.rx_data       = rx_data_q;
  assign bus.rx_parity_err = rx_perr_q;
  assign bus.rx_frame_err  = rx_ferr_q;
  assign tx_state_o        = tx_state_q;
  assign rx_state_o        = rx_state_q;

endmodule

// File: tb/tb_uart_param_core.sv
// Bench for uart_param_core: three instances (8N1, 9E2 and 8O1) driven by directed
// frames; received characters are checked against an expected queue by a monitor.
module tb_uart_param_core;

  localparam int CPB = 16;

  // ---------------------------------------------------------------- clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n;
  logic rst_bc_n;
  logic [2:0] tx_st_a, rx_st_a, tx_st_b, rx_st_b, tx_st_c, rx_st_c;

  uart_param_core_if #(.DATA_BITS(8)) ia ();
  uart_param_core_if #(.DATA_BITS(9)) ib ();
  uart_param_core_if #(.DATA_BITS(8)) ic ();

  uart_param_core #(.CLKS_PER_BIT(CPB)) u_a (
    .clk(clk), .rst_n(rst_a_n), .bus(ia.slave), .tx_state_o(tx_st_a), .rx_state_o(rx_st_a)
  );
  uart_param_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY(2), .STOP_BITS(2)) u_b (
    .clk(clk), .rst_n(rst_bc_n), .bus(ib.slave), .tx_state_o(tx_st_b), .rx_state_o(rx_st_b)
  );
  uart_param_core #(.CLKS_PER_BIT(CPB), .PARITY(1)) u_c (
    .clk(clk), .rst_n(rst_bc_n), .bus(ic.slave), .tx_state_o(tx_st_c), .rx_state_o(rx_st_c)
  );

  // B receives its own line, so its RX sees the frame with or without loopback.
  assign ib.rx_serial = ib.tx_serial;

  // ---------------------------------------------------------------- scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [10:0] exp_q_a[$];
  logic [10:0] exp_q_b[$];
  logic [10:0] exp_q_c[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int sel, input logic [10:0] e);
    case (sel)
      0:       exp_q_a.push_back(e);
      1:       exp_q_b.push_back(e);
      default: exp_q_c.push_back(e);
    endcase
  endtask

  // got/expected format: {parity_err, frame_err, data[8:0]}
  task automatic mon_rx(input int sel, input logic done, input logic prev, input logic [10:0] got);
    logic [10:0] e;
    int n;
    if (done) begin
      check($sformatf("rx%0d_no_double_pulse", sel), 32'(prev), 32'd0);
      case (sel)
        0:       n = exp_q_a.size();
        1:       n = exp_q_b.size();
        default: n = exp_q_c.size();
      endcase
      if (n == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rx%0d_spurious: got char 0x%0h expected no rx_done", sel, got);
      end else begin
        case (sel)
          0:       e = exp_q_a.pop_front();
          1:       e = exp_q_b.pop_front();
          default: e = exp_q_c.pop_front();
        endcase
        check($sformatf("rx%0d_char", sel), 32'(got), 32'(e));
      end
    end
  endtask

  initial begin : monitor
    logic pa, pb, pc;
    pa = 1'b0;
    pb = 1'b0;
    pc = 1'b0;
    forever begin
      @(negedge clk);
      mon_rx(0, ia.rx_done, pa, {ia.rx_parity_err, ia.rx_frame_err, 1'b0, ia.rx_data});
      mon_rx(1, ib.rx_done, pb, {ib.rx_parity_err, ib.rx_frame_err, ib.rx_data});
      mon_rx(2, ic.rx_done, pc, {ic.rx_parity_err, ic.rx_frame_err, 1'b0, ic.rx_data});
      pa = ia.rx_done;
      pb = ib.rx_done;
      pc = ic.rx_done;
    end
  end

  // ---------------------------------------------------------------- driver tasks
  function automatic logic busy_of(input int sel);
    case (sel)
      0:       return ia.tx_busy;
      1:       return ib.tx_busy;
      default: return ic.tx_busy;
    endcase
  endfunction

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return ia.tx_done;
      1:       return ib.tx_done;
      default: return ic.tx_done;
    endcase
  endfunction

  function automatic logic ser_of(input int sel);
    case (sel)
      0:       return ia.tx_serial;
      1:       return ib.tx_serial;
      default: return ic.tx_serial;
    endcase
  endfunction

  task automatic set_start(input int sel, input logic v, input logic [8:0] d);
    case (sel)
      0:       begin ia.tx_start = v; ia.tx_data = d[7:0]; end
      1:       begin ib.tx_start = v; ib.tx_data = d;      end
      default: begin ic.tx_start = v; ic.tx_data = d[7:0]; end
    endcase
  endtask

  // Called at a negedge; returns at the first negedge after the accepting edge.
  task automatic start_tx(input int sel, input logic [8:0] d, input bit push);
    int i;
    i = 0;
    while (busy_of(sel) && i < 2000) begin
      @(negedge clk);
      i++;
    end
    if (busy_of(sel)) begin
      n_vec++;
      n_err++;
      $display("FAIL tx%0d_idle_wait: got tx_busy 1 expected 0", sel);
    end
    if (push) push_exp(sel, {2'b00, d});
    set_start(sel, 1'b1, d);
    @(negedge clk);
    set_start(sel, 1'b0, d);
  endtask

  // Sends one character and returns on the negedge where tx_done is seen.
  task automatic xmit(input int sel, input logic [8:0] d, input int exp_len,
                      input bit chk_line, input logic exp_par, input int inj);
    int cnt;
    bit got;
    cnt = 0;
    got = 1'b0;
    start_tx(sel, d, 1'b1);
    for (int c = 1; c <= 4000 && !got; c++) begin
      if (chk_line) begin
        if (c == 8)             check("tx_start_bit", 32'(ser_of(sel)), 32'd0);
        if (c == 10 * CPB + 8)  check("tx_parity_bit", 32'(ser_of(sel)), 32'(exp_par));
        if (c == 12 * CPB + 8)  check("tx_stop2_bit", 32'(ser_of(sel)), 32'd1);
      end
      if (inj != 0 && c == inj)     set_start(sel, 1'b1, 9'h000);
      if (inj != 0 && c == inj + 1) set_start(sel, 1'b0, 9'h000);
      if (done_of(sel)) begin
        got = 1'b1;
      end else begin
        if (busy_of(sel)) cnt++;
        @(negedge clk);
      end
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL tx%0d_done_timeout: got no tx_done expected one", sel);
    end else begin
      check($sformatf("tx%0d_busy_cycles", sel), 32'(cnt), 32'(exp_len));
      check($sformatf("tx%0d_busy_low_at_done", sel), 32'(busy_of(sel)), 32'd0);
    end
  endtask

  task automatic drive_line(input int sel, input logic v, input int n);
    if (sel == 0) ia.rx_serial = v;
    else          ic.rx_serial = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_frame(input int sel, input logic [8:0] d, input int nbits,
                             input bit has_par, input logic par, input logic stop);
    drive_line(sel, 1'b0, CPB);
    for (int i = 0; i < nbits; i++) drive_line(sel, d[i], CPB);
    if (has_par) drive_line(sel, par, CPB);
    drive_line(sel, stop, CPB);
  endtask

  task automatic wait_drain();
    int i;
    i = 0;
    while ((exp_q_a.size() + exp_q_b.size() + exp_q_c.size()) != 0 && i < 3000) begin
      @(negedge clk);
      i++;
    end
    check("expected_queue_drained", 32'(exp_q_a.size() + exp_q_b.size() + exp_q_c.size()), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin : stimulus
    logic [7:0] craft[5];
    craft = '{8'h63, 8'h72, 8'h61, 8'h66, 8'h74};

    rst_a_n  = 1'b0;
    rst_bc_n = 1'b0;
    set_start(0, 1'b0, 9'h0);
    set_start(1, 1'b0, 9'h0);
    set_start(2, 1'b0, 9'h0);
    ia.rx_serial = 1'b1;
    ic.rx_serial = 1'b1;
    ia.loopback  = 1'b1;
    ib.loopback  = 1'b0;
    ic.loopback  = 1'b0;
    repeat (3) @(negedge clk);

    check("reset_tx_busy_a", 32'(ia.tx_busy), 32'd0);
    check("reset_tx_done_a", 32'(ia.tx_done), 32'd0);
    check("reset_rx_done_a", 32'(ia.rx_done), 32'd0);
    check("reset_rx_data_b", 32'(ib.rx_data), 32'd0);
    check("reset_flags_c", 32'({ic.rx_parity_err, ic.rx_frame_err}), 32'd0);
    check("reset_tx_serial_c", 32'(ic.tx_serial), 32'd1);
    check("reset_states_a", 32'({tx_st_a, rx_st_a}), 32'd0);
    rst_a_n  = 1'b1;
    rst_bc_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 loopback, back-to-back on tx_done
    xmit(0, 9'h073, 160, 1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) xmit(0, {1'b0, craft[i]}, 160, 1'b0, 1'b0, 0);
    wait_drain();

    // 9E2: line checked on the pad first, then through loopback
    xmit(1, 9'h1FF, 13 * CPB, 1'b1, 1'b1, 0);
    xmit(1, 9'h001, 13 * CPB, 1'b1, 1'b1, 0);
    wait_drain();
    ib.loopback = 1'b1;
    xmit(1, 9'h1FF, 13 * CPB, 1'b0, 1'b0, 0);
    xmit(1, 9'h001, 13 * CPB, 1'b0, 1'b0, 0);
    wait_drain();

    // odd parity: 0x41 with wrong parity 0, then good frames clear the flag
    push_exp(2, {2'b10, 9'h041});
    drive_frame(2, 9'h041, 8, 1'b1, 1'b0, 1'b1);
    drive_line(2, 1'b1, CPB);
    push_exp(2, {2'b00, 9'h042});
    drive_frame(2, 9'h042, 8, 1'b1, 1'b1, 1'b1);
    drive_line(2, 1'b1, CPB);
    push_exp(2, {2'b00, 9'h007});
    drive_frame(2, 9'h007, 8, 1'b1, 1'b0, 1'b1);
    drive_line(2, 1'b1, CPB);
    wait_drain();

    // framing error, line held low in break, then a clean 0x55
    ia.loopback = 1'b0;
    push_exp(0, {2'b01, 9'h03C});
    drive_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1'b0);
    drive_line(0, 1'b0, 3 * CPB);
    drive_line(0, 1'b1, CPB);
    push_exp(0, {2'b00, 9'h055});
    drive_frame(0, 9'h055, 8, 1'b0, 1'b0, 1'b1);
    drive_line(0, 1'b1, CPB);
    wait_drain();

    // glitch shorter than half a bit
    drive_line(0, 1'b0, CPB / 4);
    drive_line(0, 1'b1, 3 * CPB);
    check("glitch_rx_idle", 32'(rx_st_a), 32'd0);
    check("glitch_rx_data_held", 32'(ia.rx_data), 32'h55);

    // reset in the middle of the data bits of a loopback frame
    ia.loopback = 1'b1;
    start_tx(0, 9'h0C3, 1'b0);
    repeat (5 * CPB) @(negedge clk);
    rst_a_n = 1'b0;
    #1;
    check("midreset_tx_busy", 32'(ia.tx_busy), 32'd0);
    check("midreset_rx_data", 32'(ia.rx_data), 32'd0);
    check("midreset_pulses", 32'({ia.tx_done, ia.rx_done}), 32'd0);
    check("midreset_flags", 32'({ia.rx_parity_err, ia.rx_frame_err}), 32'd0);
    check("midreset_states", 32'({tx_st_a, rx_st_a}), 32'd0);
    @(negedge clk);
    rst_a_n = 1'b1;
    repeat (2) @(negedge clk);
    xmit(0, 9'h0A5, 160, 1'b0, 1'b0, 0);
    wait_drain();

    // tx_start with 0x00 while busy must be ignored
    xmit(0, 9'h05A, 160, 1'b0, 1'b0, 50);
    repeat (3 * CPB) @(negedge clk);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
